// File: rtl/plb_mst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : plb_mst_arbiter
//  Purpose  : Round-robin share of one PLB IPIF master port between pixel-
//             pipeline requesters, single-beat commands from a latched copy.
//  Revision : 1.0  initial release
// ============================================================================
module plb_mst_arbiter #(
    parameter int C_MST_AWIDTH = 32,
    parameter int C_MST_DWIDTH = 32,
    parameter int NUM_REQ      = 3
) (
    input  logic                                  Bus2IP_Clk,
    input  logic                                  Bus2IP_Resetn,
    input  logic [0:NUM_REQ-1]                    req_valid,
    input  logic [0:NUM_REQ-1]                    req_rnw,
    input  logic [0:NUM_REQ*C_MST_AWIDTH-1]       req_addr,
    input  logic [0:NUM_REQ*C_MST_DWIDTH/8-1]     req_be,
    input  logic [0:NUM_REQ*C_MST_DWIDTH-1]       req_wdata,
    output logic [0:NUM_REQ-1]                    gnt,
    output logic [0:NUM_REQ-1]                    done,
    output logic [0:NUM_REQ-1]                    err,
    output logic [0:C_MST_DWIDTH-1]               rd_data,
    output logic                                  IP2Bus_MstRd_Req,
    output logic                                  IP2Bus_MstWr_Req,
    output logic [0:C_MST_AWIDTH-1]               IP2Bus_Mst_Addr,
    output logic [0:C_MST_DWIDTH/8-1]             IP2Bus_Mst_BE,
    output logic [0:C_MST_DWIDTH-1]               IP2Bus_MstWr_d,
    output logic                                  IP2Bus_Mst_Lock,
    output logic                                  IP2Bus_Mst_Reset,
    input  logic                                  Bus2IP_Mst_CmdAck,
    input  logic                                  Bus2IP_Mst_Cmplt,
    input  logic                                  Bus2IP_Mst_Error,
    input  logic                                  Bus2IP_Mst_Rearbitrate,
    input  logic                                  Bus2IP_Mst_Cmd_Timeout,
    input  logic [0:C_MST_DWIDTH-1]               Bus2IP_MstRd_d,
    input  logic                                  Bus2IP_MstRd_src_rdy_n,
    input  logic                                  Bus2IP_MstWr_dst_rdy_n
);

    localparam int c_bew = C_MST_DWIDTH / 8;
    localparam int c_pw  = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_CMPLT = 3'd2,
        S_BACKOFF    = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [c_pw-1:0]          r_ptr;
    logic [c_pw-1:0]          r_gnt_idx;
    logic [0:NUM_REQ-1]       r_gnt;
    logic                     r_rnw;
    logic [0:C_MST_AWIDTH-1]  r_addr;
    logic [0:c_bew-1]         r_be;
    logic [0:C_MST_DWIDTH-1]  r_wdata;
    logic                     r_err_flag;
    logic [0:C_MST_DWIDTH-1]  r_rd_data;
    logic                     r_mst_reset;

    logic [c_pw-1:0]          w_cand;
    logic [c_pw-1:0]          w_win_idx;
    logic                     w_win_found;
    logic [0:NUM_REQ-1]       w_win_onehot;
    logic                     w_set_err;
    logic                     w_unused_ok;

    // Write data is held stable from the latch, so the write handshake is moot.
    assign w_unused_ok = Bus2IP_MstWr_dst_rdy_n;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        w_cand      = '0;
        w_win_idx   = '0;
        w_win_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = c_pw'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_win_found && req_valid[w_cand]) begin
                w_win_idx   = w_cand;
                w_win_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_win_onehot            = '0;
        w_win_onehot[w_win_idx] = 1'b1;
    end

    always_comb begin
        w_next_state = r_state;
        w_set_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_found)
                    w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                if (Bus2IP_Mst_CmdAck)
                    w_next_state = Bus2IP_Mst_Cmplt ? S_DONE : S_WAIT_CMPLT;
                else if (Bus2IP_Mst_Rearbitrate)
                    w_next_state = S_BACKOFF;
                else if (Bus2IP_Mst_Cmd_Timeout) begin
                    w_next_state = S_DONE;
                    w_set_err    = 1'b1;
                end
                if (Bus2IP_Mst_Error)
                    w_set_err = 1'b1;
            end
            S_WAIT_CMPLT: begin
                if (Bus2IP_Mst_Cmplt)
                    w_next_state = S_DONE;
                if (Bus2IP_Mst_Error)
                    w_set_err = 1'b1;
            end
            S_BACKOFF:    w_next_state = S_ISSUE;
            S_DONE:       w_next_state = S_IDLE;
            default:      w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_gnt_idx  <= '0;
            r_gnt      <= '0;
            r_rnw      <= 1'b0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_err_flag <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && w_win_found) begin
                r_gnt      <= w_win_onehot;
                r_gnt_idx  <= w_win_idx;
                r_rnw      <= req_rnw[w_win_idx];
                r_addr     <= req_addr[int'(w_win_idx)*C_MST_AWIDTH +: C_MST_AWIDTH];
                r_be       <= req_be[int'(w_win_idx)*c_bew +: c_bew];
                r_wdata    <= req_wdata[int'(w_win_idx)*C_MST_DWIDTH +: C_MST_DWIDTH];
                r_err_flag <= 1'b0;
            end
            if (w_set_err)
                r_err_flag <= 1'b1;
            if (r_state == S_DONE) begin
                r_gnt <= '0;
                r_ptr <= (r_gnt_idx == c_pw'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
            end
            if (r_rnw && !Bus2IP_MstRd_src_rdy_n)
                r_rd_data <= Bus2IP_MstRd_d;
        end
    end

    // Deliberately unreset: this register is the reset copy for the IPIF.
    always_ff @(posedge Bus2IP_Clk) begin
        r_mst_reset <= ~Bus2IP_Resetn;
    end

    assign gnt              = r_gnt;
    assign done             = (r_state == S_DONE) ? r_gnt : '0;
    assign err              = (r_state == S_DONE && r_err_flag) ? r_gnt : '0;
    assign rd_data          = r_rd_data;
    assign IP2Bus_MstRd_Req = (r_state == S_ISSUE) &&  r_rnw;
    assign IP2Bus_MstWr_Req = (r_state == S_ISSUE) && !r_rnw;
    assign IP2Bus_Mst_Addr  = r_addr;
    assign IP2Bus_Mst_BE    = r_be;
    assign IP2Bus_MstWr_d   = r_wdata;
    assign IP2Bus_Mst_Lock  = 1'b0;
    assign IP2Bus_Mst_Reset = r_mst_reset;

endmodule
`default_nettype wire

// File: tb/tb_plb_mst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_plb_mst_arbiter
//  Purpose  : Directed-vector self-checking bench for plb_mst_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_plb_mst_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                Bus2IP_Clk = 1'b0;
    logic                Bus2IP_Resetn;
    logic [0:N-1]        req_valid, req_rnw;
    logic [0:N*AW-1]     req_addr;
    logic [0:N*DW/8-1]   req_be;
    logic [0:N*DW-1]     req_wdata;
    logic [0:N-1]        gnt, done, err;
    logic [0:DW-1]       rd_data;
    logic                IP2Bus_MstRd_Req, IP2Bus_MstWr_Req;
    logic [0:AW-1]       IP2Bus_Mst_Addr;
    logic [0:DW/8-1]     IP2Bus_Mst_BE;
    logic [0:DW-1]       IP2Bus_MstWr_d;
    logic                IP2Bus_Mst_Lock, IP2Bus_Mst_Reset;
    logic                cmd_ack, cmplt, mst_err, rearb, timeout;
    logic [0:DW-1]       rd_d;
    logic                src_rdy_n, dst_rdy_n;

    int vecs  = 0;
    int fails = 0;

    always #5 Bus2IP_Clk = ~Bus2IP_Clk;

    plb_mst_arbiter #(.C_MST_AWIDTH(AW), .C_MST_DWIDTH(DW), .NUM_REQ(N)) dut (
        .Bus2IP_Clk             (Bus2IP_Clk),
        .Bus2IP_Resetn          (Bus2IP_Resetn),
        .req_valid              (req_valid),
        .req_rnw                (req_rnw),
        .req_addr               (req_addr),
        .req_be                 (req_be),
        .req_wdata              (req_wdata),
        .gnt                    (gnt),
        .done                   (done),
        .err                    (err),
        .rd_data                (rd_data),
        .IP2Bus_MstRd_Req       (IP2Bus_MstRd_Req),
        .IP2Bus_MstWr_Req       (IP2Bus_MstWr_Req),
        .IP2Bus_Mst_Addr        (IP2Bus_Mst_Addr),
        .IP2Bus_Mst_BE          (IP2Bus_Mst_BE),
        .IP2Bus_MstWr_d         (IP2Bus_MstWr_d),
        .IP2Bus_Mst_Lock        (IP2Bus_Mst_Lock),
        .IP2Bus_Mst_Reset       (IP2Bus_Mst_Reset),
        .Bus2IP_Mst_CmdAck      (cmd_ack),
        .Bus2IP_Mst_Cmplt       (cmplt),
        .Bus2IP_Mst_Error       (mst_err),
        .Bus2IP_Mst_Rearbitrate (rearb),
        .Bus2IP_Mst_Cmd_Timeout (timeout),
        .Bus2IP_MstRd_d         (rd_d),
        .Bus2IP_MstRd_src_rdy_n (src_rdy_n),
        .Bus2IP_MstWr_dst_rdy_n (dst_rdy_n)
    );

    task automatic tick;
        @(posedge Bus2IP_Clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rnw, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] d);
        req_rnw[i]             = rnw;
        req_addr[i*AW +: AW]   = a;
        req_be[i*4 +: 4]       = be;
        req_wdata[i*DW +: DW]  = d;
    endtask

    task automatic do_reset;
        Bus2IP_Resetn = 1'b0;
        tick; tick;
        Bus2IP_Resetn = 1'b1;
    endtask

    task automatic test_reset;
        Bus2IP_Resetn = 1'b0;
        tick; tick;
        vecs++; if (gnt !== 3'b000 || done !== 3'b000 || err !== 3'b000) begin
            fails++; $display("FAIL rst_gnt_done_err: got %b/%b/%b want 000/000/000", gnt, done, err); end
        vecs++; if (IP2Bus_MstRd_Req !== 1'b0 || IP2Bus_MstWr_Req !== 1'b0) begin
            fails++; $display("FAIL rst_req: got rd=%b wr=%b want 0/0", IP2Bus_MstRd_Req, IP2Bus_MstWr_Req); end
        vecs++; if (IP2Bus_Mst_Addr !== 32'h0 || IP2Bus_Mst_BE !== 4'h0 || IP2Bus_MstWr_d !== 32'h0 || rd_data !== 32'h0) begin
            fails++; $display("FAIL rst_data: got a=%h be=%h d=%h rd=%h want zeros", IP2Bus_Mst_Addr, IP2Bus_Mst_BE, IP2Bus_MstWr_d, rd_data); end
        vecs++; if (IP2Bus_Mst_Reset !== 1'b1 || IP2Bus_Mst_Lock !== 1'b0) begin
            fails++; $display("FAIL rst_mst_reset: got reset=%b lock=%b want 1/0", IP2Bus_Mst_Reset, IP2Bus_Mst_Lock); end
        Bus2IP_Resetn = 1'b1;
        tick;
        vecs++; if (IP2Bus_Mst_Reset !== 1'b0) begin
            fails++; $display("FAIL rst_release: got %b want 0", IP2Bus_Mst_Reset); end
    endtask

    task automatic test_single_write;
        set_req(1, 1'b0, 32'h9000_0404, 4'hF, 32'hFFFF_FFFF);
        req_valid = 3'b010;
        tick;
        vecs++; if (gnt !== 3'b010 || IP2Bus_MstWr_Req !== 1'b1 || IP2Bus_MstRd_Req !== 1'b0) begin
            fails++; $display("FAIL wr_grant: got gnt=%b wr=%b rd=%b want 010/1/0", gnt, IP2Bus_MstWr_Req, IP2Bus_MstRd_Req); end
        vecs++; if (IP2Bus_Mst_Addr !== 32'h9000_0404 || IP2Bus_Mst_BE !== 4'hF || IP2Bus_MstWr_d !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL wr_cmd: got a=%h be=%h d=%h want 90000404/f/ffffffff", IP2Bus_Mst_Addr, IP2Bus_Mst_BE, IP2Bus_MstWr_d); end
        tick;
        vecs++; if (IP2Bus_MstWr_Req !== 1'b1) begin
            fails++; $display("FAIL wr_req_hold: got %b want 1", IP2Bus_MstWr_Req); end
        cmd_ack = 1'b1;
        tick;
        cmd_ack = 1'b0;
        vecs++; if (IP2Bus_MstWr_Req !== 1'b0 || done !== 3'b000) begin
            fails++; $display("FAIL wr_after_ack: got wr=%b done=%b want 0/000", IP2Bus_MstWr_Req, done); end
        req_addr[1*AW +: AW] = 32'hDEAD_BEEF;
        tick;
        vecs++; if (IP2Bus_Mst_Addr !== 32'h9000_0404 || done !== 3'b000) begin
            fails++; $display("FAIL wr_addr_stable: got a=%h done=%b want 90000404/000", IP2Bus_Mst_Addr, done); end
        tick;
        cmplt = 1'b1;
        tick;
        cmplt = 1'b0;
        vecs++; if (done !== 3'b010 || err !== 3'b000 || IP2Bus_Mst_Addr !== 32'h9000_0404) begin
            fails++; $display("FAIL wr_done: got done=%b err=%b a=%h want 010/000/90000404", done, err, IP2Bus_Mst_Addr); end
        req_valid = 3'b000;
        tick;
        vecs++; if (done !== 3'b000 || gnt !== 3'b000) begin
            fails++; $display("FAIL wr_done_pulse: got done=%b gnt=%b want 000/000", done, gnt); end
    endtask

    task automatic test_round_robin;
        int exp_order [4] = '{0, 1, 2, 0};
        logic [0:N-1] exp_gnt;
        do_reset;
        for (int i = 0; i < N; i++)
            set_req(i, 1'b0, 32'h9000_0000 + 32'(i * 16), 4'hF, 32'h0000_0100 + 32'(i));
        req_valid = 3'b111;
        for (int n = 0; n < 4; n++) begin
            exp_gnt = 3'b100 >> exp_order[n];
            tick;
            vecs++; if (gnt !== exp_gnt || IP2Bus_Mst_Addr !== 32'h9000_0000 + 32'(exp_order[n] * 16)) begin
                fails++; $display("FAIL rr_grant_%0d: got gnt=%b a=%h want %b/%h", n, gnt, IP2Bus_Mst_Addr,
                                  exp_gnt, 32'h9000_0000 + 32'(exp_order[n] * 16)); end
            if (n == 1) req_valid[0] = 1'b1;
            cmd_ack = 1'b1; cmplt = 1'b1;
            tick;
            cmd_ack = 1'b0; cmplt = 1'b0;
            vecs++; if (done !== exp_gnt) begin
                fails++; $display("FAIL rr_done_%0d: got %b want %b", n, done, exp_gnt); end
            req_valid[exp_order[n]] = 1'b0;
            tick;
        end
    endtask

    task automatic test_read;
        set_req(2, 1'b1, 32'h9000_0000, 4'hF, 32'h0);
        req_valid = 3'b001;
        tick;
        vecs++; if (gnt !== 3'b001 || IP2Bus_MstRd_Req !== 1'b1 || IP2Bus_MstWr_Req !== 1'b0) begin
            fails++; $display("FAIL rd_grant: got gnt=%b rd=%b wr=%b want 001/1/0", gnt, IP2Bus_MstRd_Req, IP2Bus_MstWr_Req); end
        cmd_ack = 1'b1;
        tick;
        cmd_ack = 1'b0;
        vecs++; if (IP2Bus_MstRd_Req !== 1'b0 || IP2Bus_Mst_Addr !== 32'h9000_0000) begin
            fails++; $display("FAIL rd_wait: got rd=%b a=%h want 0/90000000", IP2Bus_MstRd_Req, IP2Bus_Mst_Addr); end
        cmplt = 1'b1; src_rdy_n = 1'b0; rd_d = 32'h1234_5678;
        tick;
        cmplt = 1'b0; src_rdy_n = 1'b1; rd_d = 32'h0;
        vecs++; if (done !== 3'b001 || err !== 3'b000 || rd_data !== 32'h1234_5678) begin
            fails++; $display("FAIL rd_done: got done=%b err=%b rd=%h want 001/000/12345678", done, err, rd_data); end
        req_valid = 3'b000;
        tick;
    endtask

    task automatic test_rearbitrate;
        set_req(0, 1'b0, 32'h9000_0100, 4'h3, 32'hA5A5_0000);
        req_valid = 3'b100;
        tick;
        rearb = 1'b1;
        tick;
        rearb = 1'b0;
        vecs++; if (IP2Bus_MstWr_Req !== 1'b0 || gnt !== 3'b100) begin
            fails++; $display("FAIL rearb_backoff: got wr=%b gnt=%b want 0/100", IP2Bus_MstWr_Req, gnt); end
        tick;
        vecs++; if (IP2Bus_MstWr_Req !== 1'b1 || gnt !== 3'b100 || IP2Bus_Mst_Addr !== 32'h9000_0100) begin
            fails++; $display("FAIL rearb_reissue: got wr=%b gnt=%b a=%h want 1/100/90000100", IP2Bus_MstWr_Req, gnt, IP2Bus_Mst_Addr); end
        cmd_ack = 1'b1; rearb = 1'b1; cmplt = 1'b1;
        tick;
        cmd_ack = 1'b0; rearb = 1'b0; cmplt = 1'b0;
        vecs++; if (done !== 3'b100 || err !== 3'b000) begin
            fails++; $display("FAIL rearb_ack_wins: got done=%b err=%b want 100/000", done, err); end
        req_valid = 3'b000;
        tick;
    endtask

    task automatic test_error_timeout;
        set_req(1, 1'b0, 32'h9000_0200, 4'hF, 32'h1);
        req_valid = 3'b010;
        tick;
        cmd_ack = 1'b1;
        tick;
        cmd_ack = 1'b0; mst_err = 1'b1; cmplt = 1'b1;
        tick;
        mst_err = 1'b0; cmplt = 1'b0;
        vecs++; if (done !== 3'b010 || err !== 3'b010) begin
            fails++; $display("FAIL err_cmplt: got done=%b err=%b want 010/010", done, err); end
        req_valid = 3'b000;
        tick;
        set_req(2, 1'b0, 32'h9000_0300, 4'hF, 32'h2);
        req_valid = 3'b001;
        tick;
        timeout = 1'b1;
        tick;
        timeout = 1'b0;
        vecs++; if (done !== 3'b001 || err !== 3'b001) begin
            fails++; $display("FAIL timeout: got done=%b err=%b want 001/001", done, err); end
        req_valid = 3'b000;
        tick;
        set_req(0, 1'b0, 32'h9000_0400, 4'hF, 32'h3);
        req_valid = 3'b100;
        tick;
        timeout = 1'b1; cmd_ack = 1'b1;
        tick;
        timeout = 1'b0; cmd_ack = 1'b0;
        vecs++; if (done !== 3'b000 || IP2Bus_MstWr_Req !== 1'b0) begin
            fails++; $display("FAIL timeout_ack_wins: got done=%b wr=%b want 000/0", done, IP2Bus_MstWr_Req); end
        cmplt = 1'b1;
        tick;
        cmplt = 1'b0;
        vecs++; if (done !== 3'b100 || err !== 3'b000) begin
            fails++; $display("FAIL err_cleared: got done=%b err=%b want 100/000", done, err); end
        req_valid = 3'b000;
        tick;
    endtask

    task automatic test_reset_mid;
        set_req(1, 1'b0, 32'h9000_0500, 4'hC, 32'h5);
        req_valid = 3'b010;
        tick;
        cmd_ack = 1'b1;
        tick;
        cmd_ack = 1'b0;
        Bus2IP_Resetn = 1'b0;
        tick;
        vecs++; if (gnt !== 3'b000 || done !== 3'b000 || IP2Bus_MstWr_Req !== 1'b0 || IP2Bus_Mst_Addr !== 32'h0) begin
            fails++; $display("FAIL midrst_outputs: got gnt=%b done=%b wr=%b a=%h want 000/000/0/0", gnt, done, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr); end
        vecs++; if (IP2Bus_Mst_Reset !== 1'b1) begin
            fails++; $display("FAIL midrst_mst_reset: got %b want 1", IP2Bus_Mst_Reset); end
        Bus2IP_Resetn = 1'b1;
        req_valid = 3'b000;
        set_req(0, 1'b0, 32'h9000_0600, 4'hF, 32'h6);
        set_req(2, 1'b0, 32'h9000_0700, 4'hF, 32'h7);
        tick;
        vecs++; if (done !== 3'b000 || IP2Bus_Mst_Reset !== 1'b0) begin
            fails++; $display("FAIL midrst_no_done: got done=%b rst=%b want 000/0", done, IP2Bus_Mst_Reset); end
        req_valid = 3'b101;
        tick;
        vecs++; if (gnt !== 3'b100 || IP2Bus_Mst_Addr !== 32'h9000_0600) begin
            fails++; $display("FAIL midrst_ptr: got gnt=%b a=%h want 100/90000600", gnt, IP2Bus_Mst_Addr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Bus2IP_Resetn = 1'b0;
        req_valid = '0; req_rnw = '0; req_addr = '0; req_be = '0; req_wdata = '0;
        cmd_ack = 1'b0; cmplt = 1'b0; mst_err = 1'b0; rearb = 1'b0; timeout = 1'b0;
        rd_d = '0; src_rdy_n = 1'b1; dst_rdy_n = 1'b0;
        test_reset;
        test_single_write;
        test_round_robin;
        test_read;
        test_rearbitrate;
        test_error_timeout;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
`default_nettype wire
